// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the float32 conversion/arithmetic blocks.
//   FP32 field widths and bias, converter FSM state encoding, integer
//   saturation constants and result flag bit positions.
package fp_pkg;
   localparam int FP_EXP_W  = 8;
   localparam int FP_FRAC_W = 23;
   localparam int FP_BIAS   = 127;

   localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

   localparam int FLAG_NV = 1;   // invalid operation
   localparam int FLAG_NX = 0;   // inexact

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_SIGN  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify -- combinational operand classification for float32.
//   i_a        : float32 operand
//   o_sign     : sign bit
//   o_exp      : biased exponent
//   o_zero     : +/-0
//   o_nan      : any NaN
//   o_inf      : +/-infinity
//   o_under    : |x| < 1 (exponent below bias, includes zero/denormals)
//   o_in_range : 1 <= |x| < 2^31 (fits signed int32 after truncation)
module fp32_classify
   import fp_pkg::*;
(
   input  logic [31:0]         i_a,
   output logic                o_sign,
   output logic [FP_EXP_W-1:0] o_exp,
   output logic                o_zero,
   output logic                o_nan,
   output logic                o_inf,
   output logic                o_under,
   output logic                o_in_range
);
   logic [FP_FRAC_W-1:0] w_frac;
   logic                 w_exp_max;

   assign o_sign     = i_a[31];
   assign o_exp      = i_a[30:23];
   assign w_frac     = i_a[22:0];
   assign w_exp_max  = (o_exp == 8'hFF);
   assign o_zero     = (o_exp == 8'd0) && (w_frac == '0);
   assign o_nan      = w_exp_max && (w_frac != '0);
   assign o_inf      = w_exp_max && (w_frac == '0);
   assign o_under    = (o_exp < 8'(FP_BIAS));
   assign o_in_range = (o_exp >= 8'(FP_BIAS)) && (o_exp <= 8'(FP_BIAS + 30));
endmodule

// File: rtl/fp_to_int.sv
// fp_to_int -- multi-cycle float32 -> int32 conversion, round toward zero.
//   i_clk, i_rst      : clock, async active-high reset
//   i_unsigned        : uint32 mode, only with FP_CVT_UNSIGNED_EN defined
//   i_valid / o_ready : operand handshake (accept when both high)
//   i_a               : float32 operand
//   o_valid / i_ready : result handshake
//   o_result          : int32 (or uint32) result
//   o_flags           : [1]=NV invalid, [0]=NX inexact
// The mantissa is shifted at most 4 bits per cycle toward the binary point;
// out-of-range, NaN and |x|<1 operands are resolved at accept.
module fp_to_int
   import fp_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
`ifdef FP_CVT_UNSIGNED_EN
   input  logic        i_unsigned,
`endif
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_a,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic [1:0]  o_flags
);
   state_t      r_state;
   logic [31:0] r_mag, r_result;
   logic [7:0]  r_cnt;
   logic [1:0]  r_flags;
   logic        r_dir_left, r_sign, r_uns, r_sticky, r_valid, r_ready;

   logic        w_sign, w_zero, w_nan, w_inf, w_under, w_in_range, w_uns;
   logic        w_norm, w_accept, w_lost;
   logic [7:0]  w_exp, w_cnt_ld, w_cnt_nxt;
   logic [2:0]  w_step;
   logic [31:0] w_sp_result;
   logic [1:0]  w_sp_flags;

`ifdef FP_CVT_UNSIGNED_EN
   assign w_uns = i_unsigned;
`else
   assign w_uns = 1'b0;
`endif

   fp32_classify u_cls (
      .i_a        (i_a),
      .o_sign     (w_sign),
      .o_exp      (w_exp),
      .o_zero     (w_zero),
      .o_nan      (w_nan),
      .o_inf      (w_inf),
      .o_under    (w_under),
      .o_in_range (w_in_range)
   );

   assign w_accept = i_valid && r_ready;
   // Unsigned mode gains one extra exponent (2^31..2^32) but rejects negatives.
   assign w_norm   = w_uns ? (!w_sign && (w_in_range || w_exp == 8'd158)) : w_in_range;
   // Integer point sits 150 exponents above 1.0 in the 24-bit mantissa.
   assign w_cnt_ld = (w_exp > 8'd150) ? (w_exp - 8'd150) : (8'd150 - w_exp);

   assign w_step    = (r_cnt > 8'd4) ? 3'd4 : r_cnt[2:0];
   assign w_cnt_nxt = r_cnt - {5'd0, w_step};
   assign w_lost    = |(r_mag & ((32'd1 << w_step) - 32'd1));

   always_comb begin
      w_sp_result = 32'd0;
      w_sp_flags  = 2'b00;
      if (w_nan) begin
         w_sp_result          = w_uns ? UINT_MAX : INT_MAX;
         w_sp_flags[FLAG_NV]  = 1'b1;
      end else if (w_under) begin
         w_sp_flags[FLAG_NX]  = !w_zero;
      end else if (w_inf || !w_norm) begin
         if (w_uns) w_sp_result = w_sign ? 32'd0 : UINT_MAX;
         else       w_sp_result = w_sign ? INT_MIN : INT_MAX;
         w_sp_flags[FLAG_NV]  = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_valid    <= 1'b0;
         r_ready    <= 1'b0;
         r_result   <= 32'd0;
         r_flags    <= 2'b00;
         r_cnt      <= 8'd0;
         r_mag      <= 32'd0;
         r_sticky   <= 1'b0;
         r_sign     <= 1'b0;
         r_uns      <= 1'b0;
         r_dir_left <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ready    <= 1'b0;
                  r_sign     <= w_sign;
                  r_uns      <= w_uns;
                  r_mag      <= {8'd0, 1'b1, i_a[22:0]};
                  r_dir_left <= (w_exp > 8'd150);
                  r_cnt      <= w_cnt_ld;
                  r_sticky   <= 1'b0;
                  if (w_norm) begin
                     r_state <= (w_cnt_ld == 8'd0) ? ST_SIGN : ST_SHIFT;
                  end else begin
                     r_state  <= ST_DONE;
                     r_valid  <= 1'b1;
                     r_result <= w_sp_result;
                     r_flags  <= w_sp_flags;
                  end
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (r_dir_left) begin
                  r_mag <= r_mag << w_step;
               end else begin
                  r_mag    <= r_mag >> w_step;
                  r_sticky <= r_sticky | w_lost;
               end
               r_cnt <= w_cnt_nxt;
               if (w_cnt_nxt == 8'd0) r_state <= ST_SIGN;
            end
            ST_SIGN: begin
               r_result <= (r_sign && !r_uns) ? (~r_mag + 32'd1) : r_mag;
               r_flags  <= {1'b0, r_sticky};
               r_valid  <= 1'b1;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               // Ready returns only after the handoff edge, so no overlap.
               if (i_ready) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_ready  = r_ready;
   assign o_valid  = r_valid;
   assign o_result = r_result;
   assign o_flags  = r_flags;
endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int -- directed-vector bench for fp_to_int.
// Build with FP_CVT_UNSIGNED_EN defined to also exercise uint32 mode.
module tb_fp_to_int;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b0;
   logic [31:0] i_a = 32'd0;
`ifdef FP_CVT_UNSIGNED_EN
   logic        i_unsigned = 1'b0;
`endif
   logic        o_ready, o_valid;
   logic [31:0] o_result;
   logic [1:0]  o_flags;

   int errs = 0;
   int checks = 0;

   fp_to_int dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
`ifdef FP_CVT_UNSIGNED_EN
      .i_unsigned (i_unsigned),
`endif
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_a        (i_a),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_result   (o_result),
      .o_flags    (o_flags)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Offer one operand, return result/flags and accept-to-valid latency.
   // Leaves the result un-taken; caller decides when to raise i_ready.
   task automatic offer(input logic [31:0] a, input logic uns, output int lat);
      int w;
      w = 0;
      while (!o_ready && w < 50) begin tick(); w++; end
      chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
      i_a = a;
      i_valid = 1'b1;
`ifdef FP_CVT_UNSIGNED_EN
      i_unsigned = uns;
`else
      if (uns) $display("note: unsigned request ignored in signed build");
`endif
      tick();
      i_valid = 1'b0;
      i_a = $urandom;   // operand must be ignored after accept
      lat = 1;
      while (!o_valid && lat < 60) begin tick(); lat++; end
   endtask

   task automatic take();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("valid_drops", {31'd0, o_valid}, 32'd0);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] res;
      logic [1:0]  fl;
      int          lat;
   } vec_t;

   vec_t vecs[$] = '{
      '{32'h3F800000, 32'h00000001, 2'b00, 8},  // 1.0
      '{32'hC0600000, 32'hFFFFFFFD, 2'b01, 8},  // -3.5
      '{32'h4F000000, 32'h7FFFFFFF, 2'b10, 1},  // 2^31
      '{32'hCF000000, 32'h80000000, 2'b10, 1},  // -2^31
      '{32'h7FC00000, 32'h7FFFFFFF, 2'b10, 1},  // NaN
      '{32'h3F000000, 32'h00000000, 2'b01, 1},  // 0.5
      '{32'h80000000, 32'h00000000, 2'b00, 1},  // -0
      '{32'h4B000001, 32'h00800001, 2'b00, 2},  // e=150, no shift
      '{32'h4EFFFFFF, 32'h7FFFFF80, 2'b00, 4},  // largest in range
      '{32'hCEFFFFFF, 32'h80000080, 2'b00, 4},
      '{32'h3FC00000, 32'h00000001, 2'b01, 8},  // 1.5
      '{32'h7F800000, 32'h7FFFFFFF, 2'b10, 1},  // +inf
      '{32'hFF800000, 32'h80000000, 2'b10, 1},  // -inf
      '{32'h00000001, 32'h00000000, 2'b01, 1},  // denormal
      '{32'h4B800000, 32'h01000000, 2'b00, 3}   // 2^24, left shift 1
   };

`ifdef FP_CVT_UNSIGNED_EN
   vec_t uvecs[$] = '{
      '{32'hBF800000, 32'h00000000, 2'b10, 1},  // -1.0
      '{32'h4F000000, 32'h80000000, 2'b00, 4},  // 2^31 fits uint32
      '{32'h4F800000, 32'hFFFFFFFF, 2'b10, 1},  // 2^32
      '{32'hBF000000, 32'h00000000, 2'b01, 1},  // -0.5
      '{32'h7FC00000, 32'hFFFFFFFF, 2'b10, 1},  // NaN
      '{32'hC0600000, 32'h00000000, 2'b10, 1}   // -3.5
   };
`endif

   initial begin
      int lat;
      logic [31:0] held;

      // Reset state
      tick();
      chk("rst_ready", {31'd0, o_ready}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_flags", {30'd0, o_flags}, 32'd0);
      i_rst = 1'b0;
      tick();
      chk("ready_after_rst", {31'd0, o_ready}, 32'd1);

      foreach (vecs[i]) begin
         offer(vecs[i].a, 1'b0, lat);
         chk($sformatf("res_%h", vecs[i].a), o_result, vecs[i].res);
         chk($sformatf("flg_%h", vecs[i].a), {30'd0, o_flags}, {30'd0, vecs[i].fl});
         chk($sformatf("lat_%h", vecs[i].a), lat, vecs[i].lat);
         take();
      end

      // Back-pressure: result must hold and no new operand accepted
      offer(32'h4B000001, 1'b0, lat);
      held = o_result;
      chk("hold_first", held, 32'h00800001);
      for (int k = 0; k < 5; k++) begin
         i_valid = 1'b1;
         tick();
         chk("hold_result", o_result, 32'h00800001);
         chk("hold_ready", {31'd0, o_ready}, 32'd0);
         chk("hold_valid", {31'd0, o_valid}, 32'd1);
      end
      i_valid = 1'b0;
      take();

      // Reset during SHIFT abandons the conversion
      offer(32'h3F800000, 1'b0, lat);
      chk("pre_rst_result", o_result, 32'h00000001);
      take();
      while (!o_ready) tick();
      i_a = 32'h3F800000;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      tick();             // mid-SHIFT
      i_rst = 1'b1;
      #1;
      chk("midrst_ready", {31'd0, o_ready}, 32'd0);
      chk("midrst_valid", {31'd0, o_valid}, 32'd0);
      tick();
      i_rst = 1'b0;
      tick();
      chk("ready_after_midrst", {31'd0, o_ready}, 32'd1);
      begin
         int seen = 0;
         for (int k = 0; k < 12; k++) begin
            if (o_valid) seen++;
            tick();
         end
         chk("no_valid_after_midrst", seen, 0);
      end
      offer(32'hC0600000, 1'b0, lat);
      chk("recover_res", o_result, 32'hFFFFFFFD);
      chk("recover_lat", lat, 8);
      take();

`ifdef FP_CVT_UNSIGNED_EN
      foreach (uvecs[i]) begin
         offer(uvecs[i].a, 1'b1, lat);
         chk($sformatf("ures_%h", uvecs[i].a), o_result, uvecs[i].res);
         chk($sformatf("uflg_%h", uvecs[i].a), {30'd0, o_flags}, {30'd0, uvecs[i].fl});
         chk($sformatf("ulat_%h", uvecs[i].a), lat, uvecs[i].lat);
         take();
      end
      offer(32'hBF800000, 1'b0, lat);   // same operand, signed mode
      chk("smode_res", o_result, 32'hFFFFFFFF);
      take();
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
